// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divide-controller state encoding and iteration sizing.
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration on the 64-bit {remainder, quotient} register.
module div_step
    import cpu_defs_pkg::*;
(
    input  logic [2*DIV_ITER-1:0] p_i,
    input  logic [DIV_ITER-1:0]   divisor_i,
    output logic [2*DIV_ITER-1:0] p_o
);

    logic [DIV_ITER:0] diff;

    // The top 33 bits of P before the shift equal the shifted partial remainder,
    // including the bit that falls off the left end.
    always_comb begin
        diff = p_i[2*DIV_ITER-1:DIV_ITER-1] - {1'b0, divisor_i};
        if (!diff[DIV_ITER]) begin
            p_o = {diff[DIV_ITER-1:0], p_i[DIV_ITER-2:0], 1'b1};
        end else begin
            p_o = {p_i[2*DIV_ITER-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: operand latch, 32-step restoring loop, sign fix-up.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle with a fixed result.
module div_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int ITER = DIV_ITER
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  cancel_i,
    input  logic [DIV_ITER-1:0]   opdata1_i,
    input  logic [DIV_ITER-1:0]   opdata2_i,
    output logic                  divstart,
    output logic                  ready_o,
    output logic [2*DIV_ITER-1:0] result_o
);

    div_state_t             state_q, state_d;
    logic [2*DIV_ITER-1:0]  p_q, p_d, p_step;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_ITER-1:0]    dvs_q, dvs_d;
    logic                   negq_q, negq_d;
    logic                   negr_q, negr_d;
    logic [2*DIV_ITER-1:0]  result_q, result_d;
    logic [DIV_ITER-1:0]    op1_abs, op2_abs;
    logic [DIV_ITER-1:0]    rem_raw, quo_raw;

    assign op1_abs = (signed_i && opdata1_i[DIV_ITER-1]) ? -opdata1_i : opdata1_i;
    assign op2_abs = (signed_i && opdata2_i[DIV_ITER-1]) ? -opdata2_i : opdata2_i;

    div_step u_step (
        .p_i       (p_q),
        .divisor_i (dvs_q),
        .p_o       (p_step)
    );

    assign rem_raw = p_step[2*DIV_ITER-1:DIV_ITER];
    assign quo_raw = p_step[DIV_ITER-1:0];

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        divstart = 1'b0;
        ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    divstart = 1'b1;
                    p_d      = {{DIV_ITER{1'b0}}, op1_abs};
                    cnt_d    = '0;
                    dvs_d    = op2_abs;
                    negq_d   = signed_i && (opdata1_i[DIV_ITER-1] ^ opdata2_i[DIV_ITER-1]);
                    negr_d   = signed_i && opdata1_i[DIV_ITER-1];
                    state_d  = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2_i == '0) begin
                        state_d  = DONE;
                        result_d = {opdata1_i, {DIV_ITER{1'b1}}};
                    end
`endif
                end
            end
            BUSY: begin
                divstart = 1'b1;
                p_d      = p_step;
                cnt_d    = cnt_q + DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(ITER - 1)) begin
                    state_d  = DONE;
                    result_d = {negr_q ? -rem_raw : rem_raw, negq_q ? -quo_raw : quo_raw};
                end
            end
            DONE: begin
                ready_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush overrides everything: partial work is dropped, result_o keeps its last value.
        if (cancel_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
            divstart = 1'b0;
            ready_o  = 1'b0;
        end

        if (!resetn) begin
            divstart = 1'b0;
            ready_o  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            p_q      <= '0;
            cnt_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall length, signed/unsigned results, cancel and reset.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic        cancel_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        divstart;
    logic        ready_o;
    logic [63:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    div_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .cancel_i  (cancel_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .divstart  (divstart),
        .ready_o   (ready_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; drives one divide and follows it to ready_o.
    // Leaves start_i high and returns at the falling edge of the cycle after DONE.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input bit chk_res);
        int n_stall = 0;
        int lat     = -1;
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (divstart) n_stall++;
            if (ready_o) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stalls"}, 64'(n_stall), 64'(exp_lat));
        if (chk_res) check({tag, "_result"}, result_o, exp_res);
        @(negedge clk);
    endtask

    task automatic go_idle();
        start_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit ready_seen;
        resetn    = 1'b0;
        start_i   = 1'b1;
        signed_i  = 1'b0;
        cancel_i  = 1'b0;
        opdata1_i = 32'd5;
        opdata2_i = 32'd1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_divstart", {63'd0, divstart}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        start_i = 1'b0;
        resetn  = 1'b1;
        @(negedge clk);

        // Back-to-back divides with start_i held throughout.
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1);
        run_div("divu_big", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, 1);
        go_idle();

        // Cancel during BUSY cycle 10.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd10;
        for (int c = 0; c < 10; c++) @(negedge clk);
        cancel_i = 1'b1;
        start_i  = 1'b0;
        #1;
        check("cancel_divstart", {63'd0, divstart}, 64'd0);
        check("cancel_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        #1;
        check("post_cancel_divstart", {63'd0, divstart}, 64'd0);
        ready_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (ready_o) ready_seen = 1'b1;
        end
        check("cancel_no_ready", {63'd0, ready_seen}, 64'd0);
        check("cancel_result_held", result_o, {32'd1, 32'h7FFF_FFFC});
        @(negedge clk);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1);
        go_idle();

        // Reset during BUSY cycle 5.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd16;
        for (int c = 0; c < 5; c++) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_divstart", {63'd0, divstart}, 64'd0);
        @(negedge clk);
        resetn  = 1'b1;
        start_i = 1'b0;
        #1;
        check("postrst_divstart", {63'd0, divstart}, 64'd0);
        check("postrst_ready", {63'd0, ready_o}, 64'd0);
        check("postrst_result", result_o, 64'd0);
        @(negedge clk);
        run_div("divu_ffff_16", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 33, 1);
        go_idle();

`ifdef DIV_ZERO_FAST_EN
        run_div("divu_zero_fast", 1'b0, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 1);
        go_idle();
        run_div("div_zero_fast_neg", 1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1, 1);
        go_idle();
`else
        run_div("divu_zero_slow", 1'b0, 32'h0000_1234, 32'd0, 64'd0, 33, 0);
        go_idle();
`endif
        run_div("divu_after_zero", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
